mult_div_unit: RTL and testbench

- Iterative MIPS HI/LO multiply/divide unit, directly downstream of the register file.
- Consumes the two register read ports (rs/rt operands) for MULT/MULTU/DIV/DIVU.
- Produces the HI/LO architectural registers; the datapath moves them back into the register file via MFHI/MFLO.
- Also accepts MTHI/MTLO writes; start/busy/done handshake lets control stall on HI/LO use.

---
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS HI/LO multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, WIDTH+1 edges
// from acceptance to the done pulse. MTHI/MTLO writes are taken only while idle.
// Optional macro SIGNED_OPS_EN: when defined, MULT/DIV (op[0]=1) are signed;
// otherwise op[0] is ignored and every operation is unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;      // mul: multiplicand; div: divisor
    logic               is_div;
    logic               div_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] acc_next;

    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef SIGNED_OPS_EN
    logic               sign_a;
    logic               sign_b;

    // Operand magnitudes for signed ops, raw values otherwise
    always_comb begin
        mag_a = rs_data;
        mag_b = rt_data;
        if (op[0] && rs_data[WIDTH-1]) mag_a = -rs_data;
        if (op[0] && rt_data[WIDTH-1]) mag_b = -rt_data;
    end
`else
    logic               unused_op_bit;
    assign unused_op_bit = op[0];

    // Unsigned-only build: operands are used as given
    always_comb begin
        mag_a = rs_data;
        mag_b = rt_data;
    end
`endif

    // One shift-add or restoring-divide iteration on the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // Modular subtract is exact here: a kept remainder is always below the divisor
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (div_ge) acc_next = {div_diff, acc[WIDTH-2:0], 1'b1};
            else        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Final HI/LO values, including sign fixup and divide-by-zero result
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
`ifdef SIGNED_OPS_EN
        if (!is_div) begin
            if (sign_a ^ sign_b) {res_hi, res_lo} = -acc;
        end else begin
            if (sign_a ^ sign_b) res_lo = -acc[WIDTH-1:0];
            // Remainder follows the dividend; with a zero divisor this restores rs_data
            if (sign_a)          res_hi = -acc[2*WIDTH-1:WIDTH];
        end
`endif
        if (is_div && div_zero) res_lo = '1;
    end

    // Control FSM with registered HI/LO, busy and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
`ifdef SIGNED_OPS_EN
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
`endif
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        div_zero <= (rt_data == '0);
`ifdef SIGNED_OPS_EN
                        sign_a   <= op[0] & rs_data[WIDTH-1];
                        sign_b   <= op[0] & rt_data[WIDTH-1];
`endif
                        opnd     <= op[1] ? mag_b : mag_a;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FINISH;
                end
                FINISH: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
// Expected values for MULT/DIV follow SIGNED_OPS_EN when it is defined.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
    } vec_t;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    // Pulse start for one edge, then count edges until done (bounded)
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (hi !== 32'h0)  begin nerr++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        nvec++; if (lo !== 32'h0)  begin nerr++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        vec_t v[$];
        int   e;
        v.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        v.push_back('{2'b10, 32'd100,      32'd7,        32'd2,        32'd14});
        v.push_back('{2'b10, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF});
        v.push_back('{2'b00, 32'd6,        32'd7,        32'h0,        32'd42});
        v.push_back('{2'b10, 32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF});
        v.push_back('{2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780});
        v.push_back('{2'b10, 32'd5,        32'd9,        32'd5,        32'd0});
        foreach (v[i]) begin
            launch(v[i].op, v[i].a, v[i].b, e);
            nvec++; if (e !== 33)        begin nerr++; $display("FAIL u%0d_latency: got %0d expected 33", i, e); end
            nvec++; if (hi !== v[i].eh)  begin nerr++; $display("FAIL u%0d_hi: got %h expected %h", i, hi, v[i].eh); end
            nvec++; if (lo !== v[i].el)  begin nerr++; $display("FAIL u%0d_lo: got %h expected %h", i, lo, v[i].el); end
            nvec++; if (busy !== 1'b0)   begin nerr++; $display("FAIL u%0d_busy_at_done: got %b expected 0", i, busy); end
            @(posedge clk); #1;
            nvec++; if (done !== 1'b0)   begin nerr++; $display("FAIL u%0d_done_width: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_signed;
        vec_t v[$];
        int   e;
`ifdef SIGNED_OPS_EN
        v.push_back('{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
        v.push_back('{2'b01, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'h0,        32'd24});
        v.push_back('{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        v.push_back('{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
        v.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000});
`else
        v.push_back('{2'b01, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1});
        v.push_back('{2'b01, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'hFFFFFFF6, 32'd24});
        v.push_back('{2'b11, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC});
        v.push_back('{2'b11, 32'd7,        32'hFFFFFFFE, 32'd7,        32'd0});
        v.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0});
`endif
        v.push_back('{2'b11, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF});
        foreach (v[i]) begin
            launch(v[i].op, v[i].a, v[i].b, e);
            nvec++; if (e !== 33)        begin nerr++; $display("FAIL s%0d_latency: got %0d expected 33", i, e); end
            nvec++; if (hi !== v[i].eh)  begin nerr++; $display("FAIL s%0d_hi: got %h expected %h", i, hi, v[i].eh); end
            nvec++; if (lo !== v[i].el)  begin nerr++; $display("FAIL s%0d_lo: got %h expected %h", i, lo, v[i].el); end
        end
    endtask

    task automatic test_busy_ignore;
        int           e;
        logic [W-1:0] hi_prev;
        op = 2'b10; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hi_prev = hi;
        e = 0;
        repeat (9) begin @(posedge clk); #1; e++; end
        start = 1'b1; op = 2'b00; rs_data = 32'd9; rt_data = 32'd3; hi_we = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1; e++;
        start = 1'b0; hi_we = 1'b0;
        nvec++; if (busy !== 1'b1)  begin nerr++; $display("FAIL busy_mid: got %b expected 1", busy); end
        nvec++; if (hi !== hi_prev) begin nerr++; $display("FAIL hi_we_while_busy: got %h expected %h", hi, hi_prev); end
        while (done !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
        nvec++; if (e !== 33)       begin nerr++; $display("FAIL busy_latency: got %0d expected 33", e); end
        nvec++; if (lo !== 32'd14)  begin nerr++; $display("FAIL busy_lo: got %h expected %h", lo, 32'd14); end
        nvec++; if (hi !== 32'd2)   begin nerr++; $display("FAIL busy_hi: got %h expected %h", hi, 32'd2); end
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1; hi_we = 1'b0;
        nvec++; if (hi !== 32'hAA)  begin nerr++; $display("FAIL mthi: got %h expected %h", hi, 32'hAA); end
        nvec++; if (lo !== 32'd14)  begin nerr++; $display("FAIL mthi_lo_hold: got %h expected %h", lo, 32'd14); end
        lo_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1; lo_we = 1'b0;
        nvec++; if (lo !== 32'h55)  begin nerr++; $display("FAIL mtlo: got %h expected %h", lo, 32'h55); end
        nvec++; if (hi !== 32'hAA)  begin nerr++; $display("FAIL mtlo_hi_hold: got %h expected %h", hi, 32'hAA); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h3C;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        nvec++; if (hi !== 32'h3C)  begin nerr++; $display("FAIL mthi_both: got %h expected %h", hi, 32'h3C); end
        nvec++; if (lo !== 32'h3C)  begin nerr++; $display("FAIL mtlo_both: got %h expected %h", lo, 32'h3C); end
        // start and MTHI/MTLO in the same cycle: the start must win
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77;
        op = 2'b00; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        nvec++; if (hi !== 32'h3C)  begin nerr++; $display("FAIL start_wins_hi: got %h expected %h", hi, 32'h3C); end
        nvec++; if (lo !== 32'h3C)  begin nerr++; $display("FAIL start_wins_lo: got %h expected %h", lo, 32'h3C); end
        nvec++; if (busy !== 1'b1)  begin nerr++; $display("FAIL start_wins_busy: got %b expected 1", busy); end
        e = 0;
        while (done !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
        nvec++; if (e !== 33)       begin nerr++; $display("FAIL start_wins_latency: got %0d expected 33", e); end
        nvec++; if (lo !== 32'd6)   begin nerr++; $display("FAIL start_wins_result: got %h expected %h", lo, 32'd6); end
    endtask

    task automatic test_back_to_back;
        int e;
        launch(2'b00, 32'd6, 32'd7, e);
        nvec++; if (lo !== 32'd42) begin nerr++; $display("FAIL b2b_first_lo: got %h expected %h", lo, 32'd42); end
        // launch immediately, while done is still high
        launch(2'b10, 32'd100, 32'd7, e);
        nvec++; if (e !== 33)      begin nerr++; $display("FAIL b2b_latency: got %0d expected 33", e); end
        nvec++; if (lo !== 32'd14) begin nerr++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'd14); end
        nvec++; if (hi !== 32'd2)  begin nerr++; $display("FAIL b2b_hi: got %h expected %h", hi, 32'd2); end
    endtask

    task automatic test_reset_abort;
        int e;
        int done_seen;
        op = 2'b00; rs_data = 32'hFFFFFFFF; rt_data = 32'h2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (hi !== 32'h0)  begin nerr++; $display("FAIL abort_hi: got %h expected %h", hi, 32'h0); end
        nvec++; if (lo !== 32'h0)  begin nerr++; $display("FAIL abort_lo: got %h expected %h", lo, 32'h0); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy: got %b expected 0", busy); end
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        nvec++; if (done_seen !== 0) begin nerr++; $display("FAIL abort_no_done: got %0d expected 0", done_seen); end
        launch(2'b00, 32'd6, 32'd7, e);
        nvec++; if (e !== 33)      begin nerr++; $display("FAIL post_abort_latency: got %0d expected 33", e); end
        nvec++; if (lo !== 32'd42) begin nerr++; $display("FAIL post_abort_lo: got %h expected %h", lo, 32'd42); end
        nvec++; if (hi !== 32'h0)  begin nerr++; $display("FAIL post_abort_hi: got %h expected %h", hi, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
